store_checker: RTL and testbench

//  Synthesizable self-check monitor for the processor's data-memory write port.

---
 rtl/store_checker_pkg.sv | 19 +
 rtl/store_match_table.sv | 50 +++++
 rtl/store_checker.sv | 141 ++++++++++++++
 tb/tb_store_checker.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_checker_pkg.sv
// Shared definitions for the data-memory store checker.
//   status_e : verdict / FSM state encoding, which is also the value on the status port
//              (00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT)
//   IDX_W    : width of an expected-table index (table holds up to 16 entries)
//   CNT_W    : width of match_cnt (must be able to hold 16)
package store_checker_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_PASS    = 2'b01,
      ST_FAIL    = 2'b10,
      ST_TIMEOUT = 2'b11
   } status_e;

   localparam int MAX_EXP = 16;
   localparam int IDX_W   = 4;
   localparam int CNT_W   = 5;

endpackage

// File: rtl/store_match_table.sv
// Combinational compare of one store against the table of expected stores.
//   addr, data : the store being classified
//   mask       : entries already consumed (used only when ORDERED==0)
//   idx        : next entry expected (used only when ORDERED==1)
//   hit        : the store matches an eligible entry
//   hit_idx    : index of that entry (lowest eligible index on duplicates)
module store_match_table
   import store_checker_pkg::*;
#(
   parameter int                         WIDTH    = 32,
   parameter int                         NUM_EXP  = 2,
   parameter logic [NUM_EXP*WIDTH-1:0]   EXP_ADDR = {32'd84, 32'd84},
   parameter logic [NUM_EXP*WIDTH-1:0]   EXP_DATA = {32'd7, 32'd7},
   parameter int                         ORDERED  = 1
) (
   input  logic [WIDTH-1:0]   addr,
   input  logic [WIDTH-1:0]   data,
   input  logic [NUM_EXP-1:0] mask,
   input  logic [IDX_W-1:0]   idx,
   output logic               hit,
   output logic [IDX_W-1:0]   hit_idx
);

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      if (ORDERED != 0) begin
         // Only the entry at the current index is eligible.
         for (int i = 0; i < NUM_EXP; i++) begin
            if (idx == IDX_W'(i) &&
                addr == EXP_ADDR[i*WIDTH +: WIDTH] &&
                data == EXP_DATA[i*WIDTH +: WIDTH]) begin
               hit     = 1'b1;
               hit_idx = IDX_W'(i);
            end
         end
      end else begin
         // Scan downwards so the lowest unconsumed duplicate is the one reported.
         for (int i = NUM_EXP - 1; i >= 0; i--) begin
            if (!mask[i] &&
                addr == EXP_ADDR[i*WIDTH +: WIDTH] &&
                data == EXP_DATA[i*WIDTH +: WIDTH]) begin
               hit     = 1'b1;
               hit_idx = IDX_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/store_checker.sv
// Self-check monitor for the processor's data-memory write port.
// Classifies every store against a table of expected stores, tolerates a scratch
// address window, runs a cycle watchdog and holds a sticky verdict until reset.
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   memwrite            : store strobe
//   dataadr, writedata  : store address / data
//   done, pass          : verdict reached / verdict is PASS
//   status              : 00 RUN, 01 PASS, 10 FAIL, 11 TIMEOUT (FSM state)
//   match_cnt           : expected entries matched so far
//   cycle_cnt           : RUN cycles without a verdict, frozen once done
//   err_addr, err_data  : the store that caused FAIL (0 otherwise)
module store_checker
   import store_checker_pkg::*;
#(
   parameter int                         WIDTH    = 32,
   parameter int                         NUM_EXP  = 2,
   parameter logic [NUM_EXP*WIDTH-1:0]   EXP_ADDR = {32'd84, 32'd84},
   parameter logic [NUM_EXP*WIDTH-1:0]   EXP_DATA = {32'd7, 32'd7},
   parameter int                         ORDERED  = 1,
   parameter logic [WIDTH-1:0]           SCR_LO   = 80,
   parameter logic [WIDTH-1:0]           SCR_HI   = 80,
   parameter int                         TIMEOUT  = 1000,
   parameter int                         CW       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] dataadr,
   input  logic [WIDTH-1:0] writedata,
   output logic             done,
   output logic             pass,
   output logic [1:0]       status,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CW-1:0]    cycle_cnt,
   output logic [WIDTH-1:0] err_addr,
   output logic [WIDTH-1:0] err_data
);

   localparam logic [CNT_W-1:0] LAST_MATCH = CNT_W'(NUM_EXP - 1);
   localparam logic [CW-1:0]    LAST_CYCLE = CW'(TIMEOUT - 1);

   status_e            state_q, state_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
   logic [NUM_EXP-1:0] mask_q, mask_d;
   logic [CW-1:0]      cycle_cnt_q, cycle_cnt_d;
   logic [WIDTH-1:0]   err_addr_q, err_addr_d;
   logic [WIDTH-1:0]   err_data_q, err_data_d;

   logic               hit;
   logic [IDX_W-1:0]   hit_idx;
   logic               in_scratch;
   logic               is_final;
   logic               is_stray;

   // In ordered mode the next expected entry is simply the number matched so far.
   store_match_table #(
      .WIDTH    (WIDTH),
      .NUM_EXP  (NUM_EXP),
      .EXP_ADDR (EXP_ADDR),
      .EXP_DATA (EXP_DATA),
      .ORDERED  (ORDERED)
   ) u_table (
      .addr    (dataadr),
      .data    (writedata),
      .mask    (mask_q),
      .idx     (match_cnt_q[IDX_W-1:0]),
      .hit     (hit),
      .hit_idx (hit_idx)
   );

   // An empty window (SCR_LO > SCR_HI) can never satisfy both bounds.
   assign in_scratch = (dataadr >= SCR_LO) && (dataadr <= SCR_HI);

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      mask_d      = mask_q;
      cycle_cnt_d = cycle_cnt_q;
      err_addr_d  = err_addr_q;
      err_data_d  = err_data_q;
      is_final    = 1'b0;
      is_stray    = 1'b0;

      if (state_q == ST_RUN) begin
         if (memwrite === 1'b1) begin
            if (hit) begin
               match_cnt_d = match_cnt_q + 5'd1;
               for (int i = 0; i < NUM_EXP; i++) begin
                  if (hit_idx == IDX_W'(i)) mask_d[i] = 1'b1;
               end
               is_final = (match_cnt_q == LAST_MATCH);
            end else if (!in_scratch) begin
               is_stray = 1'b1;
            end
         end else if (memwrite !== 1'b0) begin
            // An unknown strobe in simulation is treated as a bad store.
            is_stray = 1'b1;
         end

         // Final match and stray store both outrank the watchdog on the same edge.
         if (is_final) begin
            state_d = ST_PASS;
         end else if (is_stray) begin
            state_d    = ST_FAIL;
            err_addr_d = dataadr;
            err_data_d = writedata;
         end else if (cycle_cnt_q == LAST_CYCLE) begin
            state_d = ST_TIMEOUT;
         end else begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         match_cnt_q <= '0;
         mask_q      <= '0;
         cycle_cnt_q <= '0;
         err_addr_q  <= '0;
         err_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         match_cnt_q <= match_cnt_d;
         mask_q      <= mask_d;
         cycle_cnt_q <= cycle_cnt_d;
         err_addr_q  <= err_addr_d;
         err_data_q  <= err_data_d;
      end
   end

   assign status    = state_q;
   assign done      = (state_q != ST_RUN);
   assign pass      = (state_q == ST_PASS);
   assign match_cnt = match_cnt_q;
   assign cycle_cnt = cycle_cnt_q;
   assign err_addr  = err_addr_q;
   assign err_data  = err_data_q;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: four instances with different tables share one store bus.
//   0: defaults  (ordered, {(84,7),(84,7)}, TIMEOUT 1000)
//   1: ordered   {(84,7),(88,9)}, TIMEOUT 50
//   2: unordered {(84,7),(88,9)}, TIMEOUT 50
//   3: single    {(84,7)},        TIMEOUT 50
module tb_store_checker;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   logic        d_done   [4];
   logic        d_pass   [4];
   logic [1:0]  d_status [4];
   logic [4:0]  d_match  [4];
   logic [15:0] d_cycle  [4];
   logic [31:0] d_eaddr  [4];
   logic [31:0] d_edata  [4];

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   store_checker u_dut0 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(d_done[0]), .pass(d_pass[0]), .status(d_status[0]), .match_cnt(d_match[0]),
      .cycle_cnt(d_cycle[0]), .err_addr(d_eaddr[0]), .err_data(d_edata[0]));

   store_checker #(.NUM_EXP(2), .EXP_ADDR({32'd88, 32'd84}), .EXP_DATA({32'd9, 32'd7}),
                   .ORDERED(1), .TIMEOUT(50)) u_dut1 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(d_done[1]), .pass(d_pass[1]), .status(d_status[1]), .match_cnt(d_match[1]),
      .cycle_cnt(d_cycle[1]), .err_addr(d_eaddr[1]), .err_data(d_edata[1]));

   store_checker #(.NUM_EXP(2), .EXP_ADDR({32'd88, 32'd84}), .EXP_DATA({32'd9, 32'd7}),
                   .ORDERED(0), .TIMEOUT(50)) u_dut2 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(d_done[2]), .pass(d_pass[2]), .status(d_status[2]), .match_cnt(d_match[2]),
      .cycle_cnt(d_cycle[2]), .err_addr(d_eaddr[2]), .err_data(d_edata[2]));

   store_checker #(.NUM_EXP(1), .EXP_ADDR(32'd84), .EXP_DATA(32'd7),
                   .ORDERED(1), .TIMEOUT(50)) u_dut3 (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .done(d_done[3]), .pass(d_pass[3]), .status(d_status[3]), .match_cnt(d_match[3]),
      .cycle_cnt(d_cycle[3]), .err_addr(d_eaddr[3]), .err_data(d_edata[3]));

   // behavioural model: verdict 0 run, 1 pass, 2 fail, 3 timeout
   int          m_num [4] = '{2, 2, 2, 1};
   bit          m_ord [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
   int          m_to  [4] = '{1000, 50, 50, 50};
   logic [31:0] m_xa  [4][2] = '{'{32'd84, 32'd84}, '{32'd84, 32'd88}, '{32'd84, 32'd88}, '{32'd84, 32'd0}};
   logic [31:0] m_xd  [4][2] = '{'{32'd7, 32'd7}, '{32'd7, 32'd9}, '{32'd7, 32'd9}, '{32'd7, 32'd0}};

   int          m_st  [4];
   int          m_cnt [4];
   int          m_cyc [4];
   bit          m_used[4][2];
   logic [31:0] m_eaddr [4];
   logic [31:0] m_edata [4];

   task automatic model_clear();
      for (int k = 0; k < 4; k++) begin
         m_st[k] = 0; m_cnt[k] = 0; m_cyc[k] = 0;
         m_used[k][0] = 1'b0; m_used[k][1] = 1'b0;
         m_eaddr[k] = '0; m_edata[k] = '0;
      end
   endtask

   task automatic model_step(int k);
      int hit;
      hit = -1;
      if (m_st[k] != 0) return;
      if (memwrite) begin
         if (m_ord[k]) begin
            if (dataadr == m_xa[k][m_cnt[k]] && writedata == m_xd[k][m_cnt[k]]) hit = m_cnt[k];
         end else begin
            for (int i = m_num[k] - 1; i >= 0; i--)
               if (!m_used[k][i] && dataadr == m_xa[k][i] && writedata == m_xd[k][i]) hit = i;
         end
         if (hit >= 0) begin
            m_used[k][hit] = 1'b1;
            m_cnt[k]++;
            if (m_cnt[k] == m_num[k]) begin
               m_st[k] = 1;
               return;
            end
         end else if (!(dataadr >= 80 && dataadr <= 80)) begin
            m_st[k] = 2;
            m_eaddr[k] = dataadr;
            m_edata[k] = writedata;
            return;
         end
      end
      if (m_cyc[k] == m_to[k] - 1) m_st[k] = 3;
      else m_cyc[k]++;
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) model_clear();
      else for (int k = 0; k < 4; k++) model_step(k);
   end

   // scoreboard
   task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d actual=%0d expected=%0d at %0t", name, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            chk("status",    k, 32'(d_status[k]), 32'(m_st[k]));
            chk("done",      k, 32'(d_done[k]),   32'(m_st[k] != 0));
            chk("pass",      k, 32'(d_pass[k]),   32'(m_st[k] == 1));
            chk("match_cnt", k, 32'(d_match[k]),  32'(m_cnt[k]));
            chk("cycle_cnt", k, 32'(d_cycle[k]),  32'(m_cyc[k]));
            chk("err_addr",  k, d_eaddr[k],       m_eaddr[k]);
            chk("err_data",  k, d_edata[k],       m_edata[k]);
         end
      end
   end

   // driver tasks (called at a falling edge; the store is sampled on the next rising edge)
   task automatic cyc(logic mw, logic [31:0] a, logic [31:0] d);
      memwrite = mw; dataadr = a; writedata = d;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      repeat (n) cyc(1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      memwrite = 1'b0; dataadr = '0; writedata = '0;
      #2 reset = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
      @(negedge clk);
      do_reset();
      chk("rst_status", 0, 32'(d_status[0]), 32'd0);
      chk("rst_cycle",  1, 32'(d_cycle[1]),  32'd0);

      // scratch store then the expected stores
      idle(8);
      cyc(1'b1, 32'd80, 32'd5);
      cyc(1'b1, 32'd84, 32'd7);
      chk("t1_match",   0, 32'(d_match[0]),  32'd1);
      chk("t1_status",  0, 32'(d_status[0]), 32'd0);
      chk("t1_single",  3, 32'(d_status[3]), 32'd1);
      chk("t1_spass",   3, 32'(d_pass[3]),   32'd1);
      cyc(1'b1, 32'd84, 32'd7);
      chk("t1_status",  0, 32'(d_status[0]), 32'd1);
      chk("t1_pass",    0, 32'(d_pass[0]),   32'd1);
      chk("t1_match",   0, 32'(d_match[0]),  32'd2);
      chk("t1_cycle",   0, 32'(d_cycle[0]),  32'd10);
      chk("t1_ord_err", 1, d_eaddr[1],       32'd84);
      chk("t1_uno_st",  2, 32'(d_status[2]), 32'd2);
      chk("model_pin",  1, 32'(m_st[1]),     32'd2);
      idle(3);
      chk("t1_sticky",  0, 32'(d_status[0]), 32'd1);

      // out-of-order stores
      do_reset();
      cyc(1'b1, 32'd88, 32'd9);
      chk("t2_status",  1, 32'(d_status[1]), 32'd2);
      chk("t2_eaddr",   1, d_eaddr[1],       32'd88);
      chk("t2_edata",   1, d_edata[1],       32'd9);
      chk("t3_match",   2, 32'(d_match[2]),  32'd1);
      cyc(1'b1, 32'd84, 32'd7);
      chk("t3_status",  2, 32'(d_status[2]), 32'd1);
      chk("t3_pass",    2, 32'(d_pass[2]),   32'd1);
      idle(2);

      // repeated store to a consumed entry
      do_reset();
      cyc(1'b1, 32'd88, 32'd9);
      cyc(1'b1, 32'd88, 32'd9);
      chk("t3b_status", 2, 32'(d_status[2]), 32'd2);
      chk("t3b_eaddr",  2, d_eaddr[2],       32'd88);
      chk("t3b_match",  2, 32'(d_match[2]),  32'd1);
      idle(2);

      // watchdog with only scratch stores
      do_reset();
      for (int i = 0; i < 49; i++) cyc(1'b1, 32'd80, 32'(i));
      chk("t4_run",     1, 32'(d_status[1]), 32'd0);
      chk("t4_cyc49",   1, 32'(d_cycle[1]),  32'd49);
      cyc(1'b1, 32'd80, 32'd123);
      chk("t4_tmo",     1, 32'(d_status[1]), 32'd3);
      chk("t4_done",    1, 32'(d_done[1]),   32'd1);
      chk("t4_nopass",  1, 32'(d_pass[1]),   32'd0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 32'd80, 32'(i));
      chk("t4_held",    1, 32'(d_cycle[1]),  32'd49);
      chk("t4_dflt",    0, 32'(d_cycle[0]),  32'd60);
      chk("model_pin",  2, 32'(m_cyc[2]),    32'd49);

      // final match on the last watchdog cycle
      do_reset();
      cyc(1'b1, 32'd84, 32'd7);
      idle(48);
      cyc(1'b1, 32'd88, 32'd9);
      chk("t5_ord",     1, 32'(d_status[1]), 32'd1);
      chk("t5_uno",     2, 32'(d_status[2]), 32'd1);
      chk("t5_dflt",    0, 32'(d_status[0]), 32'd2);
      chk("t5_cyc",     1, 32'(d_cycle[1]),  32'd49);
      idle(2);

      // stray store on the last watchdog cycle
      do_reset();
      cyc(1'b1, 32'd84, 32'd7);
      idle(48);
      cyc(1'b1, 32'd100, 32'd1);
      chk("t5b_status", 1, 32'(d_status[1]), 32'd2);
      chk("t5b_eaddr",  1, d_eaddr[1],       32'd100);
      idle(2);

      // asynchronous reset mid-run
      do_reset();
      cyc(1'b1, 32'd84, 32'd7);
      idle(2);
      chk("t6_pre",     1, 32'(d_match[1]),  32'd1);
      #2 reset = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("t6_status", k, 32'(d_status[k]), 32'd0);
         chk("t6_match",  k, 32'(d_match[k]),  32'd0);
         chk("t6_cycle",  k, 32'(d_cycle[k]),  32'd0);
      end
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      cyc(1'b1, 32'd84, 32'd7);
      cyc(1'b1, 32'd88, 32'd9);
      chk("t6_ord",     1, 32'(d_status[1]), 32'd1);
      chk("t6_uno",     2, 32'(d_status[2]), 32'd1);
      idle(2);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
